fetch_align_queue: RTL
======================

Name: fetch_align_queue

Overview:
- Parametrised successor to the single-word RV32C fetch path.
- Decouples instruction-memory fetch from decode with a halfword queue.
- Supports multiple outstanding fetch requests, halfword-aligned redirects, and instructions that straddle word boundaries.
- Presents one aligned instruction per cycle (16-bit zero-extended or 32-bit) with its PC to the IF/ID register over a valid/ready handshake.

Parameters:
- QUEUE_HW, 8, queue depth in 16-bit halfwords; power of 2, >= 4.
- MAX_OUTSTANDING, 2, maximum fetch requests granted but not yet responded.
- RESET_PC, 32'h0000_0000, first fetch address after reset; word aligned.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- fetch_req  out  1  fetch request valid
- fetch_addr  out  32  word-aligned fetch address, bits [1:0] always 0
- fetch_gnt  in  1  memory accepts request this cycle
- fetch_rvalid  in  1  response data valid; responses arrive in request order
- fetch_rdata  in  32  response word
- redirect_valid  in  1  redirect from branch/jalr resolution or flush
- redirect_pc  in  32  redirect target, halfword aligned (bit 0 ignored)
- instr_valid  out  1  instr_data/instr_pc valid
- instr_ready  in  1  decode accepts instruction
- instr_data  out  32  instruction; compressed form zero-extended to [15:0]
- instr_pc  out  32  PC of instr_data
- instr_compressed  out  1  instr_data is a 16-bit instruction
- queue_count  out  $clog2(QUEUE_HW)+1  halfwords currently held

Behaviour:
Reset:
- fetch_req=0, fetch_addr=RESET_PC, instr_valid=0, instr_pc=RESET_PC, instr_data=0, instr_compressed=0, queue_count=0.
- Outstanding and drop counters cleared; skip_low=0.
- Reset asserted mid-operation discards all queued data and in-flight responses.

Fetch issue:
- fetch_req=1 when outstanding < MAX_OUTSTANDING, free halfwords >= 2*(outstanding+1), and redirect_valid=0.
- On fetch_req&&fetch_gnt: fetch_addr+=4 (wraps modulo 2^32) and outstanding increments.

Response:
- On fetch_rvalid: outstanding decrements.
- If drop_cnt>0: word discarded, drop_cnt decrements.
- Else if skip_low=1: only rdata[31:16] is pushed and skip_low clears.
- Otherwise both halfwords are pushed, low first.
- Response acceptance never blocks, because space is reserved at issue.

Output:
- Head halfword h0; h0[1:0]!=2'b11 means compressed.
- Compressed: instr_valid when count>=1; instr_data={16'b0,h0}.
- 32-bit: instr_valid only when count>=2; instr_data={h1,h0}. A straddling instruction waits for its upper half.
- instr_valid, instr_data, instr_pc and instr_compressed are combinational from queue head and held stable while instr_ready=0.
- On instr_valid&&instr_ready: pop 1 or 2 halfwords; instr_pc+=2 or +4 (wraps).
- Push and pop in the same cycle are allowed; count = count + pushed - popped.

Redirect (highest priority):
- Cycle N, redirect_valid=1: instr_valid forced 0, no pop, no push, fetch_req=0.
- At edge N:
  - queue emptied.
  - drop_cnt = outstanding - (fetch_rvalid ? 1 : 0).
  - fetch_addr = {redirect_pc[31:2],2'b00}.
  - instr_pc = {redirect_pc[31:1],1'b0}.
  - skip_low = redirect_pc[1].
- fetch_req may assert from N+1.
- Back-to-back redirects: the latest one wins; drop_cnt recomputed the same way.

Boundaries:
- Queue full: fetch_req=0.
- Empty, or one 32-bit lower half only: instr_valid=0.
- Stale data must never reach instr_data.

Optional Feature:
- Macro: FETCH_ALIGN_RVC_EN.
- Defined: compressed handling as above.
- Undefined:
  - every instruction treated as 32-bit; instr_compressed tied 0.
  - instr_valid requires count>=2.
  - pop is always 2 halfwords and instr_pc+=4.
  - redirect_pc[1] ignored and skip_low never set.
  - queue depth QUEUE_HW is unchanged.

Test Plan:
- Reset then memory returns words 0x00000013, 0x00100093 with 1-cycle latency, instr_ready=1 -> instr_pc=0x0 then 0x4, instr_compressed=0, fetch_addr sequence 0x0,0x4,0x8.
- Word 0x00930001 (c.nop low, 32-bit low-half upper), next word 0x00000010 -> first instr_data=0x00000001 with pc 0x0, compressed=1; then instr_data=0x00100093 with pc 0x2 only after second response arrives.
- Redirect to 0x0000_0106 with 2 outstanding -> both stale responses dropped, fetch_addr=0x104, first output is high half of word at 0x104 with instr_pc=0x106.
- instr_ready=0 for 10 cycles with QUEUE_HW=8 -> fetch_req drops once reserved space exhausted, queue_count never exceeds 8, outputs held stable, no data lost after release.
- Redirect asserted in the same cycle as fetch_rvalid and instr_ready=1 -> no pop, response discarded, drop_cnt = outstanding-1, instr_valid=0 that cycle.
- FETCH_ALIGN_RVC_EN undefined, redirect_pc=0x202 -> fetch_addr=0x200, instr_pc=0x200, every pop advances pc by 4.

Source files
------------

// File: rtl/fetch_align_queue_if.sv
// Signal bundle between fetch_align_queue, instruction memory, redirect source and decode.
// master: the aligner itself; slave: its environment.
interface fetch_align_queue_if #(
    parameter int unsigned QUEUE_HW = 8
);
    logic                      fetch_req;
    logic [31:0]               fetch_addr;
    logic                      fetch_gnt;
    logic                      fetch_rvalid;
    logic [31:0]               fetch_rdata;
    logic                      redirect_valid;
    logic [31:0]               redirect_pc;
    logic                      instr_valid;
    logic                      instr_ready;
    logic [31:0]               instr_data;
    logic [31:0]               instr_pc;
    logic                      instr_compressed;
    logic [$clog2(QUEUE_HW):0] queue_count;

    modport master (
        output fetch_req, fetch_addr,
        input  fetch_gnt, fetch_rvalid, fetch_rdata,
        input  redirect_valid, redirect_pc,
        output instr_valid, instr_data, instr_pc, instr_compressed, queue_count,
        input  instr_ready
    );

    modport slave (
        input  fetch_req, fetch_addr,
        output fetch_gnt, fetch_rvalid, fetch_rdata,
        output redirect_valid, redirect_pc,
        input  instr_valid, instr_data, instr_pc, instr_compressed, queue_count,
        output instr_ready
    );
endinterface

// File: rtl/fetch_align_queue.sv
// Halfword fetch queue that aligns RV32(C) instructions for decode.
// FETCH_ALIGN_RVC_EN enables 16-bit instruction handling; otherwise all instructions are 32-bit.
module fetch_align_queue #(
    parameter int unsigned QUEUE_HW        = 8,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input logic                 clk,
    input logic                 reset_n,
    fetch_align_queue_if.master bus
);
    localparam int unsigned PW = $clog2(QUEUE_HW);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

    logic [15:0]   mem_q [QUEUE_HW];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [OW-1:0] outst_q, outst_d, drop_q, drop_d;
    logic          skip_low_q, skip_low_d;
    logic [31:0]   faddr_q, faddr_d, pc_q, pc_d;
    logic          run_q;

    logic [15:0] h0, h1;
    logic        is_comp, avail, fetch_req, issue, resp_keep, push_one, push_two, pop;
    logic [1:0]  push_cnt, pop_cnt;
    logic [31:0] free_hw, need_hw;
    logic        unused_rpc;

    assign h0 = mem_q[rd_ptr_q];
    assign h1 = mem_q[rd_ptr_q + PW'(1)];
    assign unused_rpc = ^bus.redirect_pc[1:0];

`ifdef FETCH_ALIGN_RVC_EN
    assign is_comp = (h0[1:0] != 2'b11);
`else
    assign is_comp = 1'b0;
`endif

    assign avail = is_comp ? (count_q != '0) : (count_q >= CW'(2));

    // Space for every in-flight word plus the new one is reserved before issuing.
    assign free_hw   = 32'(QUEUE_HW) - 32'(count_q);
    assign need_hw   = (32'(outst_q) + 32'd1) << 1;
    assign fetch_req = run_q && (32'(outst_q) < 32'(MAX_OUTSTANDING)) && (free_hw >= need_hw) &&
                       !bus.redirect_valid;
    assign issue     = fetch_req && bus.fetch_gnt;

    assign resp_keep = bus.fetch_rvalid && !bus.redirect_valid && (drop_q == '0);
    assign push_one  = resp_keep && skip_low_q;
    assign push_two  = resp_keep && !skip_low_q;
    assign push_cnt  = push_two ? 2'd2 : (push_one ? 2'd1 : 2'd0);
    assign pop       = bus.instr_valid && bus.instr_ready;
    assign pop_cnt   = pop ? (is_comp ? 2'd1 : 2'd2) : 2'd0;

    // Outputs are gated by valid so stale queue contents never leak out.
    assign bus.instr_valid      = avail && !bus.redirect_valid;
    assign bus.instr_data       = !bus.instr_valid ? 32'h0 :
                                  (is_comp ? {16'h0, h0} : {h1, h0});
    assign bus.instr_compressed = bus.instr_valid && is_comp;
    assign bus.instr_pc         = pc_q;
    assign bus.fetch_req        = fetch_req;
    assign bus.fetch_addr       = faddr_q;
    assign bus.queue_count      = count_q;

    always_comb begin
        count_d    = count_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        skip_low_d = skip_low_q;
        faddr_d    = faddr_q;
        pc_d       = pc_q;
        if (bus.redirect_valid) begin
            count_d = '0;
            outst_d = outst_q - OW'(bus.fetch_rvalid);
            drop_d  = outst_q - OW'(bus.fetch_rvalid);
            faddr_d = {bus.redirect_pc[31:2], 2'b00};
`ifdef FETCH_ALIGN_RVC_EN
            pc_d       = {bus.redirect_pc[31:1], 1'b0};
            skip_low_d = bus.redirect_pc[1];
`else
            pc_d       = {bus.redirect_pc[31:2], 2'b00};
            skip_low_d = 1'b0;
`endif
        end else begin
            if (issue) faddr_d = faddr_q + 32'd4;
            outst_d = outst_q + OW'(issue) - OW'(bus.fetch_rvalid);
            if (bus.fetch_rvalid && (drop_q != '0)) drop_d = drop_q - OW'(1);
            if (push_one) skip_low_d = 1'b0;
            count_d = count_q + CW'(push_cnt) - CW'(pop_cnt);
            if (pop) pc_d = pc_q + (is_comp ? 32'd2 : 32'd4);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            skip_low_q <= 1'b0;
            faddr_q    <= RESET_PC;
            pc_q       <= RESET_PC;
            run_q      <= 1'b0;
        end else begin
            run_q      <= 1'b1;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            skip_low_q <= skip_low_d;
            faddr_q    <= faddr_d;
            pc_q       <= pc_d;
            if (bus.redirect_valid) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_q + PW'(push_cnt);
                rd_ptr_q <= rd_ptr_q + PW'(pop_cnt);
            end
        end
    end

    // Storage needs no reset: count_q alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_two) begin
            mem_q[wr_ptr_q]          <= bus.fetch_rdata[15:0];
            mem_q[wr_ptr_q + PW'(1)] <= bus.fetch_rdata[31:16];
        end else if (push_one) begin
            mem_q[wr_ptr_q] <= bus.fetch_rdata[31:16];
        end
    end
endmodule
